reg_file_sb: RTL and testbench

- Parametrised integer register file for the pipelined CPU core, with NRD combinational read ports and one write-back port.
- Adds load-data extension for sub-word loads, extended to XLEN.
- Adds write-first bypass, so a write-back is visible on the read ports in the same cycle.
- Adds a per-register busy scoreboard: set at issue, cleared at write-back. The hazard unit uses it for stall decisions.

---
 rtl/reg_file_sb.sv | 76 +++++++
 tb/tb_reg_file_sb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Integer register file with load-data extension, write-first bypass
// and a per-register busy scoreboard for the hazard unit.
module reg_file_sb #(
   parameter int  XLEN = 32,
   parameter int  NREG = 32,
   parameter int  NRD  = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NRD*AW-1:0]  raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]     rbusy,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [XLEN-1:0]    wdata,
   input  logic               wload,
   input  logic [2:0]         wfunct3,
   input  logic               issue_en,
   input  logic [AW-1:0]      issue_rd,
   input  logic               flush,
   output logic               any_busy
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [XLEN-1:0] ext;

   always_comb begin
      ext = wdata;
      if (wload) begin
         case (wfunct3)
            3'b000:  ext = XLEN'(signed'(wdata[7:0]));
            3'b001:  ext = XLEN'(signed'(wdata[15:0]));
            3'b010:  ext = XLEN'(signed'(wdata[31:0]));
            3'b100:  ext = XLEN'(wdata[7:0]);
            3'b101:  ext = XLEN'(wdata[15:0]);
            3'b110:  ext = XLEN'(wdata[31:0]);
            default: ext = wdata;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) regs[r] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= ext;
      end
   end

   // issue is applied after write-back so a new producer keeps its bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         if (we) busy[waddr] <= 1'b0;
         if (issue_en && issue_rd != '0) busy[issue_rd] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit;
      assign ra  = raddr[i*AW +: AW];
      assign hit = we && (waddr == ra);
      assign rdata[i*XLEN +: XLEN] = (ra == '0) ? '0 :
                                     hit ? ext : regs[ra];
      assign rbusy[i] = busy[ra] && !hit;
   end

   assign any_busy = |busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic
// against an array-based reference model; second instance at 64/16/3.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        wload;
   logic [2:0]  wfunct3;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        flush;
   logic        any_busy;

   logic [11:0]  b_raddr;
   logic [191:0] b_rdata;
   logic [2:0]   b_rbusy;
   logic         b_we;
   logic [3:0]   b_waddr;
   logic [63:0]  b_wdata;
   logic         b_wload;
   logic [2:0]   b_wfunct3;
   logic         b_any_busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mreg [32];
   bit          mbusy [32];

   always #5 clk = ~clk;

   reg_file_sb dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
      .rbusy(rbusy), .we(we), .waddr(waddr), .wdata(wdata),
      .wload(wload), .wfunct3(wfunct3), .issue_en(issue_en),
      .issue_rd(issue_rd), .flush(flush), .any_busy(any_busy)
   );

   reg_file_sb #(.XLEN(64), .NREG(16), .NRD(3)) dut_b (
      .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata),
      .rbusy(b_rbusy), .we(b_we), .waddr(b_waddr),
      .wdata(b_wdata), .wload(b_wload), .wfunct3(b_wfunct3),
      .issue_en(1'b0), .issue_rd(4'd0), .flush(1'b0),
      .any_busy(b_any_busy)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mext(logic [63:0] w, bit ld,
                                        logic [2:0] f, int xl);
      int n;
      bit s;
      logic [63:0] m, v, xm;
      xm = (xl == 64) ? '1 : 64'hFFFF_FFFF;
      if (!ld || f == 3'b011 || f == 3'b111) return w & xm;
      n = 8 << f[1:0];
      s = !f[2];
      m = (64'd1 << n) - 64'd1;
      v = w & m;
      if (s && v[n-1]) v = v | ~m;
      return v & xm;
   endfunction

   function automatic logic [31:0] exp_rd(logic [4:0] a);
      if (a == 0) return 32'h0;
      if (we && waddr == a) return 32'(mext(64'(wdata), wload, wfunct3, 32));
      return mreg[a];
   endfunction

   function automatic bit exp_busy(logic [4:0] a);
      return mbusy[a] && !(we && waddr == a);
   endfunction

   function automatic bit exp_any();
      bit r = 0;
      for (int k = 0; k < 32; k++) r |= mbusy[k];
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 32; k++) begin
         mreg[k] = '0;
         mbusy[k] = 0;
      end
   endtask

   // apply one rising edge to the model, per-register priority rules
   task automatic model_edge();
      logic [31:0] e;
      e = 32'(mext(64'(wdata), wload, wfunct3, 32));
      for (int r = 1; r < 32; r++) begin
         if (flush) mbusy[r] = 0;
         else if (issue_en && issue_rd == r) mbusy[r] = 1;
         else if (we && waddr == r) mbusy[r] = 0;
      end
      if (we && waddr != 0) mreg[waddr] = e;
   endtask

   task automatic idle();
      we = 0; waddr = 0; wdata = 0; wload = 0; wfunct3 = 0;
      issue_en = 0; issue_rd = 0; flush = 0;
   endtask

   // inputs are set at negedge; check, take the edge, return at negedge
   task automatic cycle();
      #1;
      for (int p = 0; p < 2; p++) begin
         chk("rdata", 64'(rdata[p*32 +: 32]), 64'(exp_rd(raddr[p*5 +: 5])));
         chk("rbusy", 64'(rbusy[p]), 64'(exp_busy(raddr[p*5 +: 5])));
      end
      chk("any_busy", 64'(any_busy), 64'(exp_any()));
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom % 4 == 0) return 5'($urandom % 32);
      return 5'($urandom % 6);
   endfunction

   logic [31:0] lext_in = 32'h0000_80F0;
   logic [2:0]  lext_f [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
   logic [31:0] lext_x [4] = '{32'hFFFF_FFF0, 32'h0000_00F0,
                               32'hFFFF_80F0, 32'h0000_80F0};

   initial begin
      rst = 0;
      raddr = 0;
      idle();
      b_raddr = 0; b_we = 0; b_waddr = 0; b_wdata = 0;
      b_wload = 0; b_wfunct3 = 0;
      model_reset();
      repeat (2) @(negedge clk);
      raddr = {5'd5, 5'd3};
      #1;
      chk("reset_rdata", rdata, 64'h0);
      chk("reset_rbusy", 64'(rbusy), 64'h0);
      chk("reset_any", 64'(any_busy), 64'h0);
      rst = 1;
      @(negedge clk);

      // load extension on REG[3]
      for (int k = 0; k < 4; k++) begin
         idle();
         we = 1; waddr = 3; wdata = lext_in; wload = 1;
         wfunct3 = lext_f[k];
         raddr = {5'd0, 5'd3};
         cycle();
         idle();
         #1;
         chk("load_ext", 64'(rdata[31:0]), 64'(lext_x[k]));
         cycle();
      end

      // bypass and x0
      idle();
      we = 1; waddr = 7; wdata = 32'hDEAD_BEEF;
      raddr = {5'd0, 5'd7};
      #1;
      chk("bypass_p0", 64'(rdata[31:0]), 64'hDEAD_BEEF);
      chk("bypass_p1_x0", 64'(rdata[63:32]), 64'h0);
      cycle();
      idle();
      we = 1; waddr = 0; wdata = 32'h55;
      cycle();
      idle();
      raddr = {5'd0, 5'd0};
      #1;
      chk("x0_write", rdata, 64'h0);
      cycle();

      // scoreboard lifecycle on x9
      idle();
      issue_en = 1; issue_rd = 9;
      raddr = {5'd9, 5'd9};
      #1;
      chk("sb_issue_same", 64'(rbusy[0]), 64'h0);
      cycle();
      idle();
      #1;
      chk("sb_busy_t1", 64'(rbusy[0]), 64'h1);
      chk("sb_any_t1", 64'(any_busy), 64'h1);
      cycle();
      cycle();
      we = 1; waddr = 9; wdata = 32'h0000_0999;
      #1;
      chk("sb_wb_bypass", 64'(rbusy[0]), 64'h0);
      cycle();
      idle();
      #1;
      chk("sb_clear", 64'(rbusy[1]), 64'h0);
      chk("sb_any_clear", 64'(any_busy), 64'h0);
      cycle();

      // simultaneous issue + write-back on x4, then with flush
      idle();
      issue_en = 1; issue_rd = 4;
      cycle();
      we = 1; waddr = 4; wdata = 32'hAAAA_0004;
      cycle();
      idle();
      raddr = {5'd4, 5'd4};
      #1;
      chk("simul_busy", 64'(rbusy[0]), 64'h1);
      chk("simul_data", 64'(rdata[31:0]), 64'hAAAA_0004);
      cycle();
      issue_en = 1; issue_rd = 4;
      we = 1; waddr = 4; wdata = 32'hBBBB_0004; flush = 1;
      cycle();
      idle();
      #1;
      chk("flush_busy", 64'(rbusy[0]), 64'h0);
      chk("flush_data", 64'(rdata[31:0]), 64'hBBBB_0004);
      cycle();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         we = 1'($urandom);
         waddr = rnd_addr();
         wdata = $urandom;
         wload = 1'($urandom);
         wfunct3 = 3'($urandom);
         issue_en = 1'($urandom);
         issue_rd = rnd_addr();
         flush = ($urandom % 16 == 0);
         raddr = {rnd_addr(), rnd_addr()};
         cycle();
      end

      // asynchronous reset mid-operation
      idle();
      we = 1; waddr = 5; wdata = 32'h1234;
      cycle();
      idle();
      issue_en = 1; issue_rd = 5;
      cycle();
      idle();
      raddr = {5'd5, 5'd5};
      we = 1; waddr = 6; wdata = 32'h6666;
      issue_en = 1; issue_rd = 6;
      #1;
      chk("pre_rst_busy", 64'(rbusy[0]), 64'h1);
      chk("pre_rst_data", 64'(rdata[31:0]), 64'h1234);
      rst = 0;
      #1;
      chk("rst_rdata", 64'(rdata[31:0]), 64'h0);
      chk("rst_rbusy", 64'(rbusy[0]), 64'h0);
      chk("rst_any", 64'(any_busy), 64'h0);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      idle();
      raddr = {5'd6, 5'd6};
      rst = 1;
      cycle();

      // 64-bit / 16-entry / 3-port instance
      b_we = 1; b_waddr = 1; b_wdata = 64'h1111_1111_8000_0000;
      b_wload = 1; b_wfunct3 = 3'b010;
      @(negedge clk);
      b_waddr = 15; b_wfunct3 = 3'b110;
      @(negedge clk);
      b_we = 0; b_wload = 0;
      b_raddr = {4'd15, 4'd15, 4'd1};
      #1;
      chk("p64_lw", b_rdata[63:0], 64'hFFFF_FFFF_8000_0000);
      chk("p64_lwu", b_rdata[127:64], 64'h0000_0000_8000_0000);
      chk("p64_port2", b_rdata[191:128], 64'h0000_0000_8000_0000);
      chk("p64_busy", 64'({b_rbusy, b_any_busy}), 64'h0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
